generador_pasos: RTL and testbench

Step/direction pulse generator that drives a downstream bidirectional saturating counter (`nxt`/`dir` interface) from a commanded target position. It tracks the position the counter must hold, emits one `nxt` pulse per unit of distance with a programmable pulse period, and sets `dir` a fixed number of cycles before the first pulse. It sits between the control logic and the position counter, and is the initiator side of the `nxt`/`dir` interface.

---
 rtl/generador_pasos_pkg.sv | 6 +
 rtl/generador_pasos_temporizador_fase.sv | 19 +
 rtl/generador_pasos.sv | 113 +++++++++++
 tb/tb_generador_pasos.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/generador_pasos_pkg.sv
// generador_pasos_pkg: state encoding and direction constants shared by the step generator
package generador_pasos_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, HIGH = 2'd2, LOW = 2'd3} estado_t;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
endpackage

// File: rtl/generador_pasos_temporizador_fase.sv
// temporizador_fase: loadable down-counter timing both the setup gap and the pulse phases
module temporizador_fase
    import generador_pasos_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] carga,
    output logic         zero
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = start ? carga : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign zero = cnt_q == '0;
endmodule

// File: rtl/generador_pasos.sv
// generador_pasos: step/direction pulse generator mirroring the downstream counter position
module generador_pasos #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8,
    parameter int SETUP = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] target,
    input  logic [DIV_W-1:0] period,
    input  logic             abort,
    output logic             nxt,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pos
);
    import generador_pasos_pkg::*;
    localparam logic [DIV_W-1:0] SETUP_CARGA = DIV_W'(SETUP - 1);
    estado_t est_q, est_d;
    logic [WIDTH-1:0] tgt_q, tgt_d, pos_q, pos_d;
    logic [DIV_W-1:0] per_q, per_d, carga;
    logic dir_q, dir_d, nxt_q, nxt_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;
    logic start, zero, sube;
    temporizador_fase #(.W(DIV_W)) u_tmp (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .carga (carga),
        .zero  (zero)
    );
    always_comb begin
        est_d   = est_q;
        tgt_d   = tgt_q;
        per_d   = per_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        abort_d = abort_q | (abort && est_q != IDLE);
        start   = 1'b0;
        carga   = per_q - 1'b1;
        sube    = tgt_q > pos_q;
        case (est_q)
            IDLE: if (load) begin
                tgt_d = target;
                per_d = period == '0 ? DIV_W'(1) : period;
                if (target == pos_q) done_d = 1'b1;
                else begin
                    dir_d = target > pos_q ? DIR_UP : DIR_DN;
                    est_d = generador_pasos_pkg::SETUP;
                    start = 1'b1;
                    carga = SETUP_CARGA;
                end
            end
            generador_pasos_pkg::SETUP: if (zero) begin
                est_d = HIGH;
                start = 1'b1;
            end
            HIGH: if (zero) begin
                est_d = LOW;
                start = 1'b1;
            end
            LOW: if (zero) begin
                if (pos_q == tgt_q || abort_q) begin
                    est_d  = IDLE;
                    done_d = 1'b1;
                end else if ((sube ? DIR_UP : DIR_DN) == dir_q) begin
                    est_d = HIGH;
                    start = 1'b1;
                end else begin
                    dir_d = sube ? DIR_UP : DIR_DN;
                    est_d = generador_pasos_pkg::SETUP;
                    start = 1'b1;
                    carga = SETUP_CARGA;
                end
            end
        endcase
        // A load mid-move only retargets; the period stays fixed until the move ends
        if (load && est_q != IDLE) tgt_d = target;
        if (est_d == HIGH && est_q != HIGH) pos_d = dir_d == DIR_UP ? pos_q + 1'b1 : pos_q - 1'b1;
        if (est_d == IDLE) abort_d = 1'b0;
        nxt_d  = est_d == HIGH;
        busy_d = est_d != IDLE;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            est_q   <= IDLE;
            tgt_q   <= '0;
            per_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            nxt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            est_q   <= est_d;
            tgt_q   <= tgt_d;
            per_q   <= per_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            nxt_q   <= nxt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    assign nxt  = nxt_q;
    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pos  = pos_q;
endmodule

// File: tb/tb_generador_pasos.sv
// tb_generador_pasos: directed checks of step timing, retarget, abort, bounds and reset
module tb_generador_pasos;
    logic clk = 1'b0, rst = 1'b1, load = 1'b0, abort = 1'b0;
    logic [3:0] target = '0;
    logic [7:0] period = '0;
    logic nxt, dir, busy, done;
    logic [3:0] pos;
    logic [3:0] cnt_m;
    int n_cmp = 0, n_bad = 0;
    int pulses, hi_cycles, done_at, first_rise, last_rise, dir_viol;
    logic dir1, busy1;

    generador_pasos #(.WIDTH(4), .DIV_W(8), .SETUP(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .target (target),
        .period (period),
        .abort  (abort),
        .nxt    (nxt),
        .dir    (dir),
        .busy   (busy),
        .done   (done),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    // Downstream bidirectional saturating counter
    always @(posedge nxt or posedge rst)
        if (rst) cnt_m <= '0;
        else if (dir) cnt_m <= cnt_m == 4'd15 ? cnt_m : cnt_m + 1'b1;
        else cnt_m <= cnt_m == 4'd0 ? cnt_m : cnt_m - 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_load(input logic [3:0] t, input logic [7:0] p);
        load = 1'b1;
        target = t;
        period = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic track(input int lim, input int inj_at, input logic inj_ld,
                         input logic [3:0] inj_tgt, input logic inj_ab);
        logic prev_n, prev_d;
        pulses = 0; hi_cycles = 0; done_at = -1; first_rise = -1; last_rise = -1; dir_viol = 0;
        prev_n = 1'b0; prev_d = dir;
        for (int rel = 1; rel <= lim; rel++) begin
            if (nxt) hi_cycles++;
            if (nxt && !prev_n) begin
                pulses++;
                if (first_rise < 0) first_rise = rel;
                last_rise = rel;
            end
            if (nxt && dir != prev_d) dir_viol++;
            if (rel == 1) begin dir1 = dir; busy1 = busy; end
            if (rel == inj_at) begin load = inj_ld; target = inj_tgt; abort = inj_ab; end
            else begin load = 1'b0; abort = 1'b0; end
            if (done) begin done_at = rel; break; end
            prev_n = nxt;
            prev_d = dir;
            @(negedge clk);
        end
        load = 1'b0;
        abort = 1'b0;
        if (done_at < 0) chk("timeout", 1, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_nxt", nxt, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pos", pos, 0);

        do_load(4'd5, 8'd3);
        track(200, 0, 0, 0, 0);
        chk("up_dir", dir1, 1);
        chk("up_busy", busy1, 1);
        chk("up_first", first_rise, 3);
        chk("up_last", last_rise, 27);
        chk("up_pulses", pulses, 5);
        chk("up_hi", hi_cycles, 15);
        chk("up_done_at", done_at, 33);
        chk("up_pos", pos, 5);
        chk("up_cnt", cnt_m, 5);
        chk("up_dirstable", dir_viol, 0);
        @(negedge clk);
        chk("up_done_pulse", done, 0);
        chk("up_busy_end", busy, 0);

        do_load(4'd2, 8'd0);
        track(200, 0, 0, 0, 0);
        chk("dn_dir", dir1, 0);
        chk("dn_pulses", pulses, 3);
        chk("dn_hi", hi_cycles, 3);
        chk("dn_done_at", done_at, 9);
        chk("dn_pos", pos, 2);
        chk("dn_cnt", cnt_m, 2);

        do_load(4'd2, 8'd4);
        track(20, 0, 0, 0, 0);
        chk("null_done_at", done_at, 1);
        chk("null_busy", busy1, 0);
        chk("null_pulses", pulses, 0);

        do_load(4'd0, 8'd1);
        track(100, 0, 0, 0, 0);
        chk("ret_home", pos, 0);
        do_load(4'd10, 8'd2);
        track(200, 11, 1, 4'd1, 0);
        chk("ret_pulses", pulses, 5);
        chk("ret_last", last_rise, 21);
        chk("ret_done_at", done_at, 25);
        chk("ret_pos", pos, 1);
        chk("ret_dir", dir, 0);
        chk("ret_cnt", cnt_m, 1);
        chk("ret_dirstable", dir_viol, 0);

        do_load(4'd0, 8'd1);
        track(100, 0, 0, 0, 0);
        do_load(4'd15, 8'd1);
        track(200, 9, 0, 0, 1);
        chk("ab_pulses", pulses, 4);
        chk("ab_done_at", done_at, 11);
        chk("ab_pos", pos, 4);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("ab_idle_busy", busy, 0);
        chk("ab_idle_nxt", nxt, 0);
        chk("ab_idle_pos", pos, 4);
        do_load(4'd6, 8'd1);
        track(100, 0, 0, 0, 0);
        chk("ab_after_pulses", pulses, 2);
        chk("ab_after_done_at", done_at, 7);
        chk("ab_after_pos", pos, 6);

        do_load(4'd0, 8'd1);
        track(100, 0, 0, 0, 0);
        chk("fr_home", pos, 0);
        do_load(4'd15, 8'd1);
        track(200, 0, 0, 0, 0);
        chk("fr_up_pulses", pulses, 15);
        chk("fr_up_done_at", done_at, 33);
        chk("fr_up_pos", pos, 15);
        chk("fr_full", cnt_m == 4'd15, 1);
        do_load(4'd0, 8'd1);
        track(200, 0, 0, 0, 0);
        chk("fr_dn_pulses", pulses, 15);
        chk("fr_dn_pos", pos, 0);
        chk("fr_empty", cnt_m == 4'd0, 1);

        do_load(4'd8, 8'd3);
        for (int i = 0; i < 20 && !nxt; i++) @(negedge clk);
        chk("rm_saw_nxt", nxt, 1);
        #2 rst = 1'b1;
        #1;
        chk("rm_nxt", nxt, 0);
        chk("rm_dir", dir, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_pos", pos, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_load(4'd3, 8'd1);
        track(100, 0, 0, 0, 0);
        chk("rm_after_pulses", pulses, 3);
        chk("rm_after_done_at", done_at, 9);
        chk("rm_after_pos", pos, 3);
        chk("rm_after_cnt", cnt_m, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
